// File: rtl/mem_clock_arbiter_if.sv
// Request/ack and RAM bus bundle between the memory arbiter, its two requesters and the sync RAM.
// The master side is the environment: VGA scanout, CPU core and the RAM read port.
interface mem_clock_arbiter_if #(
   parameter int AW = 17,
   parameter int DW = 8
);
   logic          vga_req;
   logic [AW-1:0] vga_addr;
   logic          vga_ack;
   logic [DW-1:0] vga_data;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_ack;
   logic [DW-1:0] cpu_rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport master (
      output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      input  vga_ack, vga_data, cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
   );

   modport slave (
      input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      output vga_ack, vga_data, cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/mem_clock_arbiter.sv
// Shared video/CPU memory arbiter in the memory clock domain, with PLL-lock gating
// and the CPU clock-enable divider.
module mem_clock_arbiter #(
   parameter int AW        = 17,
   parameter int DW        = 8,
   parameter int LOCK_WAIT = 16,
   parameter int CPU_DIV   = 32
) (
   input  logic                 clkin,
   input  logic                 rst,
   input  logic                 locked,
   output logic                 ready,
   output logic                 cpu_ce,
   mem_clock_arbiter_if.slave   bus
);
   localparam int LCW = $clog2(LOCK_WAIT + 1);
   localparam int DVW = $clog2(CPU_DIV);
   localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_WAIT - 1);
   localparam logic [DVW-1:0] DIV_LAST  = DVW'(CPU_DIV - 1);

   typedef enum logic [2:0] {
      BOOT  = 3'd0,
      IDLE  = 3'd1,
      VGA_A = 3'd2,
      VGA_D = 3'd3,
      CPU_A = 3'd4,
      CPU_D = 3'd5,
      CPU_W = 3'd6
   } state_t;

   state_t         state_r;
   logic [LCW-1:0] lock_cnt_r;
   logic [DVW-1:0] div_r;

   // Arbitration FSM, lock qualification and CPU clock-enable divider with registered outputs.
   always_ff @(posedge clkin) begin
      if (rst) begin
         state_r       <= BOOT;
         lock_cnt_r    <= '0;
         div_r         <= '0;
         ready         <= 1'b0;
         cpu_ce        <= 1'b0;
         bus.vga_ack   <= 1'b0;
         bus.cpu_ack   <= 1'b0;
         bus.vga_data  <= '0;
         bus.cpu_rdata <= '0;
         bus.mem_addr  <= '0;
         bus.mem_we    <= 1'b0;
         bus.mem_wdata <= '0;
      end else begin
         bus.vga_ack <= 1'b0;
         bus.cpu_ack <= 1'b0;
         bus.mem_we  <= 1'b0;
         cpu_ce      <= 1'b0;
         if (ready) begin
            if (div_r == DIV_LAST) begin
               div_r  <= '0;
               cpu_ce <= 1'b1;
            end else begin
               div_r <= div_r + DVW'(1);
            end
         end
         // Losing lock outside BOOT aborts whatever is in flight; later assignments override the above.
         if ((state_r != BOOT) && !locked) begin
            state_r    <= BOOT;
            lock_cnt_r <= '0;
            ready      <= 1'b0;
            div_r      <= '0;
            cpu_ce     <= 1'b0;
         end else begin
            case (state_r)
               BOOT: begin
                  if (locked) begin
                     if (lock_cnt_r == LOCK_LAST) begin
                        state_r    <= IDLE;
                        ready      <= 1'b1;
                        lock_cnt_r <= '0;
                     end else begin
                        lock_cnt_r <= lock_cnt_r + LCW'(1);
                     end
                  end else begin
                     lock_cnt_r <= '0;
                  end
               end
               IDLE: begin
                  // A requester still seeing its ack this cycle has not dropped req yet.
                  if (bus.vga_req && !bus.vga_ack) begin
                     bus.mem_addr <= bus.vga_addr;
                     state_r      <= VGA_A;
                  end else if (bus.cpu_req && !bus.cpu_ack) begin
                     bus.mem_addr <= bus.cpu_addr;
                     if (bus.cpu_we) begin
                        bus.mem_wdata <= bus.cpu_wdata;
                        bus.mem_we    <= 1'b1;
                        state_r       <= CPU_W;
                     end else begin
                        state_r <= CPU_A;
                     end
                  end else begin
                     state_r <= IDLE;
                  end
               end
               VGA_A: state_r <= VGA_D;
               VGA_D: begin
                  bus.vga_data <= bus.mem_rdata;
                  bus.vga_ack  <= 1'b1;
                  state_r      <= IDLE;
               end
               CPU_A: state_r <= CPU_D;
               CPU_D: begin
                  bus.cpu_rdata <= bus.mem_rdata;
                  bus.cpu_ack   <= 1'b1;
                  state_r       <= IDLE;
               end
               CPU_W: begin
                  bus.cpu_ack <= 1'b1;
                  state_r     <= IDLE;
               end
               default: begin
                  state_r    <= BOOT;
                  lock_cnt_r <= '0;
                  ready      <= 1'b0;
                  div_r      <= '0;
               end
            endcase
         end
      end
   end
endmodule
